// File: rtl/gru_stream_sequencer.sv
// Streams x_t words into a register frame, launches one GRU step, and streams
// the resulting h_t back out while keeping it as the next step's h_t_prev.
module gru_stream_sequencer #(
  parameter int D          = 64,
  parameter int H          = 16,
  parameter int DATA_WIDTH = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  input  logic                    clear_state,
  output logic [D*DATA_WIDTH-1:0] gru_x_t,
  output logic [H*DATA_WIDTH-1:0] gru_h_prev,
  output logic                    gru_start,
  input  logic                    gru_done,
  input  logic [H*DATA_WIDTH-1:0] gru_h_t,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    frame_err,
  output logic [15:0]             step_count
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int IW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic [W-1:0]   x_mem [D];
  logic [W-1:0]   h_mem [H];
  logic [W-1:0]   obuf  [H];
  logic [15:0]    step_cnt_q;
  logic           frame_err_q;
  logic           cnt_last;
  logic           idx_last;

  // Both streams use plain valid/ready: a word moves on a rising edge where
  // valid and ready are both high; the sender holds data stable until then.

  assign cnt_last = (cnt == CW'(D - 1));
  assign idx_last = (idx == IW'(H - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    gru_start  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && cnt_last) state_next = START;
      end
      START: begin
        gru_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (gru_done) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && idx_last) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      step_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < D; i++) x_mem[i] <= '0;
      for (int k = 0; k < H; k++) begin
        h_mem[k] <= '0;
        obuf[k]  <= '0;
      end
    end else begin
      if (state == LOAD) begin
        if (in_valid) begin
          x_mem[cnt] <= in_data;
          if (cnt_last) begin
            // A full frame is still processed even when in_last is missing.
            cnt <= '0;
            if (!in_last) frame_err_q <= 1'b1;
          end else if (in_last) begin
            cnt         <= '0;
            frame_err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        if (clear_state && (cnt == '0)) begin
          for (int k = 0; k < H; k++) h_mem[k] <= '0;
        end
      end

      if ((state == WAIT) && gru_done) begin
        for (int k = 0; k < H; k++) begin
          obuf[k]  <= gru_h_t[k*W +: W];
          h_mem[k] <= gru_h_t[k*W +: W];
        end
        step_cnt_q <= step_cnt_q + 16'd1;
      end

      if ((state == DRAIN) && out_ready) begin
        idx <= idx_last ? '0 : idx + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < D; gi++) begin : g_x_flat
    assign gru_x_t[gi*W +: W] = x_mem[gi];
  end

  for (genvar gk = 0; gk < H; gk++) begin : g_h_flat
    assign gru_h_prev[gk*W +: W] = h_mem[gk];
  end

  assign out_data   = (state == DRAIN) ? obuf[idx] : '0;
  assign out_last   = (state == DRAIN) && idx_last;
  assign frame_err  = frame_err_q;
  assign step_count = step_cnt_q;

endmodule

// File: tb/tb_gru_stream_sequencer.sv
// Directed bench for gru_stream_sequencer: a table of GRU steps plus
// hand-written reset, framing-error and counter-wrap sequences.
module tb_gru_stream_sequencer;

  localparam int D = 64;
  localparam int H = 16;
  localparam int W = 21;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           clear_state;
  logic [D*W-1:0] gru_x_t;
  logic [H*W-1:0] gru_h_prev;
  logic           gru_start;
  logic           gru_done;
  logic [H*W-1:0] gru_h_t;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           busy;
  logic           frame_err;
  logic [15:0]    step_count;

  gru_stream_sequencer #(.D(D), .H(H), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .clear_state(clear_state),
    .gru_x_t(gru_x_t), .gru_h_prev(gru_h_prev), .gru_start(gru_start),
    .gru_done(gru_done), .gru_h_t(gru_h_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .frame_err(frame_err), .step_count(step_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_pulses = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0] bp_pat = 4'b1001;

  always @(posedge clk) if (gru_start === 1'b1) start_pulses++;

  typedef struct {
    logic        do_clear;
    logic        mid_clear;
    int          x_base;
    int          h_base;
    logic        hp_zero;
    int          hp_base;
    logic        bp;
    logic        stray;
    logic        no_last;
    logic [15:0] exp_step;
    logic        exp_err;
  } step_vec_t;

  step_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int v);
    logic [31:0] t;
    t = v;
    return t[W-1:0];
  endfunction

  function automatic step_vec_t set_vec(input logic do_clear, input logic mid_clear,
                                        input int x_base, input int h_base,
                                        input logic hp_zero, input int hp_base,
                                        input logic bp, input logic stray, input logic no_last,
                                        input logic [15:0] exp_step, input logic exp_err);
    step_vec_t v;
    v.do_clear = do_clear;  v.mid_clear = mid_clear;
    v.x_base   = x_base;    v.h_base    = h_base;
    v.hp_zero  = hp_zero;   v.hp_base   = hp_base;
    v.bp       = bp;        v.stray     = stray;
    v.no_last  = no_last;   v.exp_step  = exp_step;
    v.exp_err  = exp_err;
    return v;
  endfunction

  // driver: entered and left on a falling edge
  task automatic send_words(input int n, input int x_base, input int last_at, input logic mid_clear);
    for (int i = 0; i < n; i++) begin
      in_valid    = 1'b1;
      in_data     = mk(x_base + i);
      in_last     = (i == last_at);
      clear_state = mid_clear && (i == 5);
      check("in_ready_load", in_ready, 1);
      @(negedge clk);
    end
    in_valid    = 1'b0;
    in_last     = 1'b0;
    clear_state = 1'b0;
    in_data     = '0;
  endtask

  task automatic check_frame(input string tag, input step_vec_t v);
    for (int i = 0; i < D; i++)
      check({tag, "_x_t"}, gru_x_t[i*W +: W], mk(v.x_base + i));
    for (int k = 0; k < H; k++)
      check({tag, "_h_prev"}, gru_h_prev[k*W +: W], v.hp_zero ? '0 : mk(v.hp_base + k));
  endtask

  task automatic run_step(input step_vec_t v);
    int sp0;
    int guard;
    logic stalled;
    logic [W-1:0] held;
    sp0 = start_pulses;
    if (v.do_clear) begin
      clear_state = 1'b1;
      @(negedge clk);
      clear_state = 1'b0;
    end
    send_words(D, v.x_base, v.no_last ? -1 : D - 1, v.mid_clear);
    check("start_after_last", gru_start, 1);
    check("busy_start", busy, 1);
    check("in_ready_start", in_ready, 0);
    check_frame("start", v);
    @(negedge clk);
    check("start_one_cycle", gru_start, 0);
    check("out_valid_wait", out_valid, 0);
    repeat (9) @(negedge clk);
    check("start_pulse_count", start_pulses, sp0 + 1);
    check_frame("wait_hold", v);
    gru_done = 1'b1;
    for (int k = 0; k < H; k++) begin
      gru_h_t[k*W +: W] = mk(v.h_base + k);
      exp_q.push_back(mk(v.h_base + k));
    end
    @(negedge clk);
    gru_done = v.stray;
    if (v.stray) for (int k = 0; k < H; k++) gru_h_t[k*W +: W] = mk(9999);
    check("first_out_latency", out_valid, 1);
    guard   = 0;
    stalled = 1'b0;
    held    = '0;
    while (exp_q.size() > 0 && guard < 200) begin
      if (guard == 1) gru_done = 1'b0;
      out_ready = v.bp ? bp_pat[guard % 4] : 1'b1;
      in_valid  = v.bp;
      in_data   = mk(12345);
      if (v.bp) check("in_ready_drain", in_ready, 0);
      check("out_valid_drain", out_valid, 1);
      if (stalled) check("out_stable", out_data, held);
      check("out_data", out_data, exp_q[0]);
      check("out_last", out_last, (exp_q.size() == 1));
      stalled = !out_ready;
      held    = out_data;
      if (out_valid && out_ready) void'(exp_q.pop_front());
      guard++;
      @(negedge clk);
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    gru_done  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("out_valid_after", out_valid, 0);
    check("out_last_after", out_last, 0);
    check("out_data_after", out_data, 0);
    check("busy_after", busy, 0);
    check("in_ready_after", in_ready, 1);
    check("step_count", step_count, v.exp_step);
    check("frame_err", frame_err, v.exp_err);
    check("single_start", start_pulses, sp0 + 1);
  endtask

  initial begin
    int sp;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; clear_state = 1'b0;
    gru_done = 1'b0; gru_h_t = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gru_start", gru_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_step", step_count, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_x_t", gru_x_t[0 +: W], 0);
    check("rst_h_prev", gru_h_prev[0 +: W], 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    //                   clr mid  x     h     hpz hp    bp stray nolast step err
    vecs[0] = set_vec(0,  0,   1,    100,  1,  0,    0, 0,    0,     1,   0);
    vecs[1] = set_vec(0,  0,   65,   200,  0,  100,  1, 1,    0,     2,   0);
    vecs[2] = set_vec(1,  0,   -40,  -500, 1,  0,    0, 0,    0,     3,   0);
    vecs[3] = set_vec(0,  1,   1000, 700,  0,  -500, 1, 0,    0,     4,   0);
    vecs[4] = set_vec(0,  0,   5,    50,   0,  700,  0, 0,    1,     5,   1);
    for (int n = 0; n < 5; n++) run_step(vecs[n]);

    // reset during WAIT, then a stray completion
    send_words(D, 3, D - 1, 1'b0);
    check("wait_rst_start", gru_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gru_done = 1'b1;
    for (int k = 0; k < H; k++) gru_h_t[k*W +: W] = mk(77);
    @(negedge clk);
    gru_done = 1'b0;
    check("wrst_out_valid", out_valid, 0);
    check("wrst_busy", busy, 0);
    check("wrst_in_ready", in_ready, 1);
    check("wrst_step", step_count, 0);
    check("wrst_frame_err", frame_err, 0);
    check("wrst_x_t", gru_x_t[0 +: W], 0);
    check("wrst_h_prev", gru_h_prev[0 +: W], 0);
    repeat (3) @(negedge clk);
    check("wrst_out_valid_late", out_valid, 0);
    check("wrst_out_data", out_data, 0);

    // early in_last discards the frame
    sp = start_pulses;
    send_words(10, 1, 9, 1'b0);
    check("early_frame_err", frame_err, 1);
    check("early_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("early_no_start", start_pulses, sp);
    check("early_in_ready", in_ready, 1);
    run_step(set_vec(0, 0, 1, 100, 1, 0, 0, 0, 0, 1, 1));

    // counter wrap
    force dut.step_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.step_cnt_q;
    @(negedge clk);
    check("wrap_preload", step_count, 16'hFFFF);
    run_step(set_vec(0, 0, 2, 40, 0, 100, 0, 0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
